cpu_run_monitor: RTL and testbench

//  Parametrised run controller/monitor that sits between the bench clock and CPU_Top.

---
 rtl/cpu_run_monitor_if.sv | 42 ++++
 rtl/cpu_run_monitor.sv | 190 +++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_monitor_if.sv
// Signal bundle between the CPU-side driver and cpu_run_monitor.
// master = CPU/bench side driving strobes and flags, slave = the monitor.
interface cpu_run_monitor_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  // Handshake: no valid/ready pair here; every strobe (start, writePC, writeIR,
  // writeReg) and flag (done, err) is a one-cycle event sampled on the rising
  // CP edge, and every output reflects the registered state one cycle later.
  logic              start;
  logic              writePC;
  logic              writeIR;
  logic              writeReg;
  logic [PC_W-1:0]   PC;
  logic [DATA_W-1:0] IR;
  logic [DATA_W-1:0] F;
  logic              done;
  logic              err;
  logic              cpu_reset;
  logic              running;
  logic              finished;
  logic [2:0]        status;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  instr_cnt;
  logic [CNT_W-1:0]  wreg_cnt;
  logic [DATA_W-1:0] last_IR;
  logic [DATA_W-1:0] signature;
  logic [1:0]        dbg_state;

  modport master (
    output start, writePC, writeIR, writeReg, PC, IR, F, done, err,
    input  cpu_reset, running, finished, status, cycle_cnt, instr_cnt,
           wreg_cnt, last_IR, signature, dbg_state
  );

  modport slave (
    input  start, writePC, writeIR, writeReg, PC, IR, F, done, err,
    output cpu_reset, running, finished, status, cycle_cnt, instr_cnt,
           wreg_cnt, last_IR, signature, dbg_state
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller/monitor for CPU_Top: reset sequencing, run counters and end-of-run status.
// Optional F signature register is built only when CPU_MON_SIGNATURE_EN is defined.
module cpu_run_monitor #(
  parameter int PC_W       = 8,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1500,
  parameter int HANG_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input logic               CP,
  input logic               reset,
  cpu_run_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RSTSEQ = 2'd1,
    S_RUN    = 2'd2,
    S_TERM   = 2'd3
  } state_t;

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_ERR     = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_HANG    = 3'd4;

  localparam int RCNT_W = $clog2(RST_CYCLES + 1);
  localparam int HCNT_W = $clog2(HANG_LIMIT) + 1;

  state_t              state_q, state_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic [2:0]          status_q, status_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]    instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0]    wreg_cnt_q, wreg_cnt_d;
  logic [DATA_W-1:0]   last_ir_q, last_ir_d;
  logic [PC_W-1:0]     last_pc_q, last_pc_d;
  logic                pc_valid_q, pc_valid_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;

  logic                pc_match;
  logic [HCNT_W-1:0]   hcnt_inc;
  logic                hang_hit;
  logic                timeout_hit;
  logic                launch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The first writePC of a run has no reference PC, so it can never match.
  assign pc_match    = pc_valid_q && (mon.PC == last_pc_q);
  assign hcnt_inc    = hcnt_q + HCNT_W'(1);
  assign hang_hit    = mon.writePC && pc_match && (hcnt_inc == HCNT_W'(HANG_LIMIT - 1));
  assign timeout_hit = (cycle_cnt_q == CNT_W'(TIMEOUT - 1));
  assign launch      = mon.start && ((state_q == S_IDLE) || (state_q == S_TERM));

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    status_d    = status_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    wreg_cnt_d  = wreg_cnt_q;
    last_ir_d   = last_ir_q;
    last_pc_d   = last_pc_q;
    pc_valid_d  = pc_valid_q;
    hcnt_d      = hcnt_q;

    case (state_q)
      S_IDLE, S_TERM: begin
        if (mon.start) begin
          state_d     = S_RSTSEQ;
          rcnt_d      = '0;
          status_d    = ST_NONE;
          cycle_cnt_d = '0;
          instr_cnt_d = '0;
          wreg_cnt_d  = '0;
          last_ir_d   = '0;
          last_pc_d   = '0;
          pc_valid_d  = 1'b0;
          hcnt_d      = '0;
        end
      end
      S_RSTSEQ: begin
        if (rcnt_q == RCNT_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      S_RUN: begin
        // The exit cycle itself is still counted; the terminal state freezes afterwards.
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        if (mon.writeIR)  instr_cnt_d = sat_inc(instr_cnt_q);
        if (mon.writeReg) wreg_cnt_d  = sat_inc(wreg_cnt_q);
        if (mon.writePC) begin
          last_pc_d  = mon.PC;
          pc_valid_d = 1'b1;
          hcnt_d     = pc_match ? hcnt_inc : '0;
        end
        if (mon.err) begin
          state_d  = S_TERM;
          status_d = ST_ERR;
        end else if (mon.done) begin
          state_d  = S_TERM;
          status_d = ST_PASS;
        end else if (hang_hit) begin
          state_d  = S_TERM;
          status_d = ST_HANG;
        end else if (timeout_hit) begin
          state_d  = S_TERM;
          status_d = ST_TIMEOUT;
        end
        if (state_d == S_TERM) last_ir_d = mon.IR;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so the CPU sees reset released exactly on the RUN entry edge.
    cpu_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge CP or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rcnt_q      <= '0;
      cpu_reset_q <= 1'b1;
      status_q    <= ST_NONE;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      wreg_cnt_q  <= '0;
      last_ir_q   <= '0;
      last_pc_q   <= '0;
      pc_valid_q  <= 1'b0;
      hcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      cpu_reset_q <= cpu_reset_d;
      status_q    <= status_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      wreg_cnt_q  <= wreg_cnt_d;
      last_ir_q   <= last_ir_d;
      last_pc_q   <= last_pc_d;
      pc_valid_q  <= pc_valid_d;
      hcnt_q      <= hcnt_d;
    end
  end

`ifdef CPU_MON_SIGNATURE_EN
  logic [DATA_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (launch) begin
      sig_d = '0;
    end else if ((state_q == S_RUN) && mon.writeReg) begin
      sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ mon.F;
    end
  end

  always_ff @(posedge CP or posedge reset) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign mon.signature = sig_q;
`else
  assign mon.signature = '0;
`endif

  assign mon.cpu_reset = cpu_reset_q;
  assign mon.running   = (state_q == S_RUN);
  assign mon.finished  = (state_q == S_TERM);
  assign mon.status    = status_q;
  assign mon.cycle_cnt = cycle_cnt_q;
  assign mon.instr_cnt = instr_cnt_q;
  assign mon.wreg_cnt  = wreg_cnt_q;
  assign mon.last_IR   = last_ir_q;
  assign mon.dbg_state = state_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: stimulus pushes expected end-of-run records,
// a negedge monitor pops and compares them when finished rises.
module tb_cpu_run_monitor;
  localparam int PC_W       = 8;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 32;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 100;
  localparam int HANG_LIMIT = 4;
  localparam int EXP_W      = 3 + 3 * CNT_W + 2 * DATA_W;
`ifdef CPU_MON_SIGNATURE_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CP    = 1'b0;
  logic reset = 1'b1;
  always #5 CP = ~CP;

  cpu_run_monitor_if #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  cpu_run_monitor #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES),
    .TIMEOUT(TIMEOUT), .HANG_LIMIT(HANG_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .CP(CP),
    .reset(reset),
    .mon(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack_exp(input logic [2:0] st, input logic [CNT_W-1:0] cyc,
      input logic [CNT_W-1:0] ins, input logic [CNT_W-1:0] wr, input logic [DATA_W-1:0] ir,
      input logic [DATA_W-1:0] sg);
    return {st, cyc, ins, wr, ir, sg};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic drive(input bit st, input bit wpc, input logic [7:0] pc, input bit wir,
      input bit wrg, input logic [31:0] f, input logic [31:0] ir, input bit dn, input bit er);
    bus.start    = st;
    bus.writePC  = wpc;
    bus.PC       = pc;
    bus.writeIR  = wir;
    bus.writeReg = wrg;
    bus.F        = f;
    bus.IR       = ir;
    bus.done     = dn;
    bus.err      = er;
    tick();
  endtask

  task automatic idle();
    bus.start    = 1'b0;
    bus.writePC  = 1'b0;
    bus.writeIR  = 1'b0;
    bus.writeReg = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    tick();
  endtask

  // Pulses start and returns how many cycles passed before running rose.
  task automatic do_start(output int rst_len);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rstseq_cpu_reset", bus.cpu_reset, 1);
    rst_len = 0;
    while (!bus.running && rst_len < 20) begin
      tick();
      rst_len++;
    end
    check("run_entered", bus.running, 1);
    check("run_cpu_reset_low", bus.cpu_reset, 0);
  endtask

  task automatic wait_finished(input int limit, output int n);
    n = 0;
    while (!bus.finished && n < limit) begin
      idle();
      n++;
    end
    check("finish_within_bound", bus.finished, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic fin_prev = 1'b0;
  always @(negedge CP) begin
    logic [EXP_W-1:0]  e;
    logic [2:0]        e_st;
    logic [CNT_W-1:0]  e_cyc, e_ins, e_wr;
    logic [DATA_W-1:0] e_ir, e_sg;
    if (bus.finished && !fin_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish: got status %0d, expected no run end", bus.status);
      end else begin
        e = exp_q.pop_front();
        {e_st, e_cyc, e_ins, e_wr, e_ir, e_sg} = e;
        check("status", bus.status, e_st);
        check("cycle_cnt", bus.cycle_cnt, e_cyc);
        check("instr_cnt", bus.instr_cnt, e_ins);
        check("wreg_cnt", bus.wreg_cnt, e_wr);
        check("last_IR", bus.last_IR, e_ir);
        check("signature", bus.signature, e_sg);
      end
    end
    fin_prev = bus.finished;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [31:0] f;
    bus.start = 0; bus.writePC = 0; bus.PC = '0; bus.writeIR = 0; bus.writeReg = 0;
    bus.IR = '0; bus.F = '0; bus.done = 0; bus.err = 0;

    repeat (3) @(posedge CP);
    #1;
    check("rst_cpu_reset", bus.cpu_reset, 1);
    check("rst_running", bus.running, 0);
    check("rst_finished", bus.finished, 0);
    check("rst_status", bus.status, 0);
    check("rst_cycle_cnt", bus.cycle_cnt, 0);
    check("rst_signature", bus.signature, 0);
    @(negedge CP);
    reset = 1'b0;
    idle();
    check("idle_cpu_reset", bus.cpu_reset, 1);

    // 1: 10 instructions, 4 register writes, done in RUN cycle 50
    exp_q.push_back(pack_exp(3'd1, 51, 10, 4, 32'hA000_0032, SIG_EN ? 32'h0000_0120 : 32'h0));
    do_start(n);
    check("rstseq_len", n, RST_CYCLES);
    for (int k = 0; k <= 50; k++) begin
      f = (k == 20) ? 32'h1 : (k == 22) ? 32'h2 : (k == 24) ? 32'h10 : 32'h100;
      drive(0, 0, 8'h00, (k >= 1 && k <= 10), (k == 20 || k == 22 || k == 24 || k == 26),
            f, 32'hA000_0000 | 32'(k), (k == 50), 0);
      if (k == 20) check("sig_first_write", bus.signature, SIG_EN ? 32'h1 : 32'h0);
      if (k == 22) check("sig_two_writes", bus.signature, 32'h0);
    end
    check("pass_running_low", bus.running, 0);
    check("pass_cpu_reset_high", bus.cpu_reset, 1);
    idle();

    // 2: err and done together; start mid-run is ignored
    exp_q.push_back(pack_exp(3'd2, 6, 0, 0, 32'hDEAD_BEEF, 32'h0));
    do_start(n);
    for (int k = 0; k <= 5; k++) begin
      drive((k == 2), 0, 8'h00, 0, 0, 32'h0,
            (k == 5) ? 32'hDEAD_BEEF : (32'h1111_0000 | 32'(k)), (k == 5), (k == 5));
      if (k == 2) check("start_ignored_in_run", bus.running, 1);
    end
    idle();

    // 3: idle CPU runs into TIMEOUT
    exp_q.push_back(pack_exp(3'd3, TIMEOUT, 0, 0, 32'h3333_3333, 32'h0));
    bus.IR = 32'h3333_3333;
    do_start(n);
    wait_finished(TIMEOUT + 20, n);
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_cpu_reset", bus.cpu_reset, 1);
    idle();

    // 4a: same PC written four times in a row
    exp_q.push_back(pack_exp(3'd4, 6, 0, 0, 32'h4444_0005, 32'h0));
    do_start(n);
    for (int k = 0; k <= 5; k++) begin
      drive(0, (k >= 2), 8'h20, 0, 0, 32'h0, 32'h4444_0000 | 32'(k), 0, 0);
    end
    idle();

    // 4b: 20,21,20,20,20,20 hangs only on the sixth pulse
    exp_q.push_back(pack_exp(3'd4, 11, 0, 0, 32'h5555_000A, 32'h0));
    do_start(n);
    for (int k = 0; k <= 10; k++) begin
      drive(0, (k % 2 == 0), (k == 2) ? 8'h21 : 8'h20, 0, 0, 32'h0,
            32'h5555_0000 | 32'(k), 0, 0);
      if (k == 8) check("no_hang_fifth_pulse", bus.finished, 0);
    end
    idle();

    // 5: async reset at RUN cycle 30 aborts the run
    do_start(n);
    for (int k = 0; k < 30; k++) idle();
    check("pre_abort_cycle_cnt", bus.cycle_cnt, 30);
    #2;
    reset = 1'b1;
    #1;
    check("abort_cpu_reset", bus.cpu_reset, 1);
    check("abort_running", bus.running, 0);
    check("abort_finished", bus.finished, 0);
    check("abort_status", bus.status, 0);
    check("abort_cycle_cnt", bus.cycle_cnt, 0);
    check("abort_last_IR", bus.last_IR, 0);
    @(negedge CP);
    reset = 1'b0;
    idle();
    exp_q.push_back(pack_exp(3'd1, 3, 0, 0, 32'h6666_0002, 32'h0));
    do_start(n);
    check("rerun_rstseq_len", n, RST_CYCLES);
    for (int k = 0; k <= 2; k++) begin
      drive(0, 0, 8'h00, 0, 0, 32'h0, 32'h6666_0000 | 32'(k), (k == 2), 0);
    end
    idle();
    idle();

    check("queue_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
